// File: rtl/uart_line_editor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_line_editor_pkg
// Description : Shared constants for the UART terminal blocks. Holds the ASCII
//               control codes the line editor decodes or emits, and the editor
//               FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_line_editor_pkg;

  typedef logic [7:0] byte_t;

  // ASCII codes
  localparam byte_t CH_BEL      = 8'h07;
  localparam byte_t CH_BS       = 8'h08;
  localparam byte_t CH_LF       = 8'h0A;
  localparam byte_t CH_CR       = 8'h0D;
  localparam byte_t CH_SP       = 8'h20;
  localparam byte_t CH_DEL      = 8'h7F;
  localparam byte_t CH_PRINT_LO = 8'h20;
  localparam byte_t CH_PRINT_HI = 8'h7E;

  // Editor FSM state encodings
  typedef logic [2:0] state_t;
  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_PROMPT = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_ECHO   = 3'd3;
  localparam logic [2:0] S_ERASE  = 3'd4;
  localparam logic [2:0] S_BELL   = 3'd5;
  localparam logic [2:0] S_NL     = 3'd6;
  localparam logic [2:0] S_DRAIN  = 3'd7;

  function automatic logic is_printable(input byte_t b);
    return (b >= CH_PRINT_LO) && (b <= CH_PRINT_HI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_line_editor_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_line_editor_if
// Description : Byte-stream bundle around the line editor.
//               RX side  : rx_get (pop), rx_data (show-ahead head), rx_empty
//               TX side  : tx_put (write strobe), tx_data, tx_full
//               Line out : out_valid, out_data, out_last, out_ready
//               master = line editor, slave = surrounding buffers/consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_line_editor_if;
  import uart_line_editor_pkg::*;

  logic  rx_get;
  byte_t rx_data;
  logic  rx_empty;

  logic  tx_put;
  byte_t tx_data;
  logic  tx_full;

  logic  out_valid;
  byte_t out_data;
  logic  out_last;
  logic  out_ready;

  modport master (
    output rx_get,
    input  rx_data,
    input  rx_empty,
    output tx_put,
    output tx_data,
    input  tx_full,
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  rx_get,
    output rx_data,
    output rx_empty,
    input  tx_put,
    input  tx_data,
    output tx_full,
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/uart_line_editor_line_ram.sv
`default_nettype none
// ============================================================================
// Module      : uart_line_editor_line_ram
// Description : DEPTH x 8 line buffer, one synchronous write port and one
//               synchronous read port with read enable (read data holds when
//               rd_en_i is low). Written to map onto a simple dual-port BRAM.
//   clk        in   clock
//   wr_en_i    in   write strobe
//   wr_addr_i  in   write address
//   wr_data_i  in   write byte
//   rd_en_i    in   read strobe, data appears next cycle
//   rd_addr_i  in   read address
//   rd_data_o  out  registered read byte
// Revision    : 1.0 - initial release
// ============================================================================
module uart_line_editor_line_ram
  import uart_line_editor_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  byte_t         wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output byte_t         rd_data_o
);

  byte_t mem_q [DEPTH];
  byte_t rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // No reset on the read register so it maps onto the BRAM output latch;
  // the editor masks it while no line byte is being presented.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/uart_line_editor.sv
`default_nettype none
// ============================================================================
// Module      : uart_line_editor
// Description : Line-editing terminal between a UART RX byte buffer and a UART
//               TX byte buffer. Echoes printable input into a line buffer,
//               handles BS/DEL, folds CR/LF pairs, prints a prompt and streams
//               each completed line to a downstream consumer.
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   bus         if   master side of uart_line_editor_if (RX, TX, line out)
//   echo_en_i   in   1: echo edits; 0: silent (prompt and CRLF still sent)
//   overflow_o  out  sticky: a printable byte was dropped on a full line
// Revision    : 1.0 - initial release
// ============================================================================
module uart_line_editor
  import uart_line_editor_pkg::*;
#(
  parameter int                    LINE_MAX       = 64,
  parameter int                    PROMPT_LEN     = 2,
  parameter logic [8*PROMPT_LEN-1:0] PROMPT       = "$ ",
  parameter int                    STARTUP_CYCLES = 32768
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_line_editor_if.master       bus,
  input  logic                     echo_en_i,
  output logic                     overflow_o
);

  localparam int CW = $clog2(LINE_MAX + 1);
  localparam int AW = $clog2(LINE_MAX);
  localparam int PW = $clog2(PROMPT_LEN + 1);
  localparam int WW = $clog2(STARTUP_CYCLES + 1);

  localparam logic [CW-1:0] LINE_FULL  = CW'(LINE_MAX);
  localparam logic [PW-1:0] PROMPT_END = PW'(PROMPT_LEN - 1);
  localparam logic [WW-1:0] WAIT_END   = WW'(STARTUP_CYCLES - 1);

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [PW-1:0] pidx_q, pidx_d;
  logic [1:0]    step_q, step_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          cr_seen_q, cr_seen_d;
  byte_t         byte_q, byte_d;
  byte_t         pend_q, pend_d;
  logic          pend_valid_q, pend_valid_d;
  logic          out_valid_q, out_valid_d;
  logic          overflow_q, overflow_d;

  logic          w_rx_get;
  logic          w_tx_put;
  logic          w_slot_free;
  logic          w_accept;
  logic          w_last;
  byte_t         w_prompt_byte;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_waddr;
  logic          w_ram_re;
  logic [AW-1:0] w_ram_raddr;
  byte_t         w_ram_rdata;

  // Strobes are gated by rst so nothing is popped or written while resetting.
  assign w_rx_get    = !rst && (state_q == S_IDLE) && !bus.rx_empty;
  assign w_tx_put    = !rst && pend_valid_q && !bus.tx_full;
  // The pending slot may be refilled in the same cycle it is drained.
  assign w_slot_free = !pend_valid_q || w_tx_put;
  assign w_accept    = out_valid_q && bus.out_ready;
  assign w_last      = out_valid_q && (idx_q == count_q - CW'(1));

  always_comb begin
    w_prompt_byte = 8'h00;
    for (int k = 0; k < PROMPT_LEN; k++) begin
      if (pidx_q == PW'(k)) begin
        w_prompt_byte = PROMPT[8*(PROMPT_LEN-1-k) +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    pidx_d       = pidx_q;
    step_d       = step_q;
    count_d      = count_q;
    idx_d        = idx_q;
    cr_seen_d    = cr_seen_q;
    byte_d       = byte_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    out_valid_d  = out_valid_q;
    overflow_d   = overflow_q;
    w_ram_we     = 1'b0;
    w_ram_waddr  = AW'(count_q);
    w_ram_re     = 1'b0;
    w_ram_raddr  = AW'(idx_q + CW'(1));

    if (w_tx_put) begin
      pend_valid_d = 1'b0;
    end

    case (state_q)
      S_WAIT: begin
        if (wait_q == WAIT_END) begin
          state_d = S_PROMPT;
          pidx_d  = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      S_PROMPT: begin
        if (w_slot_free) begin
          pend_d       = w_prompt_byte;
          pend_valid_d = 1'b1;
          if (pidx_q == PROMPT_END) begin
            pidx_d  = '0;
            state_d = S_IDLE;
          end else begin
            pidx_d = pidx_q + PW'(1);
          end
        end
      end

      S_IDLE: begin
        if (w_rx_get) begin
          byte_d = bus.rx_data;
          if (bus.rx_data != CH_LF) begin
            cr_seen_d = 1'b0;
          end
          if (bus.rx_data == CH_CR) begin
            cr_seen_d = 1'b1;
            state_d   = S_NL;
          end else if (bus.rx_data == CH_LF) begin
            // LF directly after CR belongs to the same Enter: swallow it.
            if (cr_seen_q) begin
              cr_seen_d = 1'b0;
            end else begin
              state_d = S_NL;
            end
          end else if ((bus.rx_data == CH_BS) || (bus.rx_data == CH_DEL)) begin
            if (count_q != '0) begin
              count_d = count_q - CW'(1);
              state_d = S_ERASE;
            end else begin
              state_d = S_BELL;
            end
          end else if (is_printable(bus.rx_data)) begin
            if (count_q < LINE_FULL) begin
              w_ram_we = 1'b1;
              count_d  = count_q + CW'(1);
              state_d  = S_ECHO;
            end else begin
              overflow_d = 1'b1;
              state_d    = S_BELL;
            end
          end
        end
      end

      S_ECHO: begin
        if (!echo_en_i) begin
          state_d = S_IDLE;
        end else if (w_slot_free) begin
          pend_d       = byte_q;
          pend_valid_d = 1'b1;
          state_d      = S_IDLE;
        end
      end

      S_ERASE: begin
        if (!echo_en_i) begin
          state_d = S_IDLE;
        end else if (w_slot_free) begin
          pend_d       = (step_q == 2'd1) ? CH_SP : CH_BS;
          pend_valid_d = 1'b1;
          if (step_q == 2'd2) begin
            step_d  = 2'd0;
            state_d = S_IDLE;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end

      S_BELL: begin
        if (!echo_en_i) begin
          state_d = S_IDLE;
        end else if (w_slot_free) begin
          pend_d       = CH_BEL;
          pend_valid_d = 1'b1;
          state_d      = S_IDLE;
        end
      end

      S_NL: begin
        if (w_slot_free) begin
          pend_d       = (step_q == 2'd0) ? CH_CR : CH_LF;
          pend_valid_d = 1'b1;
          if (step_q == 2'd1) begin
            step_d = 2'd0;
            if (count_q != '0) begin
              // Fetch byte 0 now so it is presented on the first drain cycle.
              w_ram_re    = 1'b1;
              w_ram_raddr = '0;
              idx_d       = '0;
              out_valid_d = 1'b1;
              state_d     = S_DRAIN;
            end else begin
              pidx_d  = '0;
              state_d = S_PROMPT;
            end
          end else begin
            step_d = 2'd1;
          end
        end
      end

      S_DRAIN: begin
        if (w_accept) begin
          if (w_last) begin
            out_valid_d = 1'b0;
            count_d     = '0;
            idx_d       = '0;
            pidx_d      = '0;
            state_d     = S_PROMPT;
          end else begin
            // Read of the next byte is issued on acceptance; with the read
            // data held otherwise, the presented byte stays stable.
            w_ram_re = 1'b1;
            idx_d    = idx_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_WAIT;
      wait_q       <= '0;
      pidx_q       <= '0;
      step_q       <= 2'd0;
      count_q      <= '0;
      idx_q        <= '0;
      cr_seen_q    <= 1'b0;
      byte_q       <= 8'h00;
      pend_q       <= 8'h00;
      pend_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      pidx_q       <= pidx_d;
      step_q       <= step_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      cr_seen_q    <= cr_seen_d;
      byte_q       <= byte_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  uart_line_editor_line_ram #(
    .DEPTH (LINE_MAX),
    .AW    (AW)
  ) u_line_ram (
    .clk       (clk),
    .wr_en_i   (w_ram_we),
    .wr_addr_i (w_ram_waddr),
    .wr_data_i (bus.rx_data),
    .rd_en_i   (w_ram_re),
    .rd_addr_i (w_ram_raddr),
    .rd_data_o (w_ram_rdata)
  );

  assign bus.rx_get    = w_rx_get;
  assign bus.tx_put    = w_tx_put;
  assign bus.tx_data   = pend_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_valid_q ? w_ram_rdata : 8'h00;
  assign bus.out_last  = w_last;
  assign overflow_o    = overflow_q;

endmodule
`default_nettype wire
